timer_module: RTL and testbench

Programmable one-shot countdown timer. A rising edge on start_timer loads a 16-bit cycle count; timer_done asserts exactly that many ticks later and holds until the next start or reset. It is used by the game controller for timed delays, e.g. the card-reveal hold time before mismatched cards flip back.

---
 rtl/timer_module.sv | 112 +++++++++++
 tb/tb_timer_module.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_module.sv
// One-shot countdown timer: a rising edge on start_timer loads delay, and timer_done
// asserts (sticky) once that many prescaled ticks have elapsed.
module timer_module #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [WIDTH-1:0] delay,
    output logic             timer_done,
    output logic             timer_busy,
    output logic [WIDTH-1:0] remaining
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [PsW-1:0]   ps_q, ps_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             start_prev_q, start_prev_d;

    logic start_evt;
    logic tick;

    assign start_evt = start_timer & ~start_prev_q;
    // With PRESCALE=1 the prescaler is stuck at 0, so every clk is a tick.
    assign tick      = (ps_q == PsLast);

    // Next-state logic: start acceptance, prescaling and countdown.
    always_comb begin
        state_d      = state_q;
        ps_d         = ps_q;
        rem_d        = rem_q;
        done_d       = done_q;
        busy_d       = busy_q;
        start_prev_d = start_timer;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_evt) begin
                    ps_d   = '0;
                    done_d = 1'b0;
                    if (delay != '0) begin
                        state_d = StRun;
                        rem_d   = delay;
                        busy_d  = 1'b1;
                    end else begin
                        // Zero delay completes on the accept edge itself.
                        state_d = StDone;
                        done_d  = 1'b1;
                        rem_d   = '0;
                    end
                end
            end
            StRun: begin
                // Start events are ignored while counting.
                if (tick) begin
                    ps_d  = '0;
                    rem_d = rem_q - WIDTH'(1);
                    if (rem_q == WIDTH'(1)) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    ps_d = ps_q + PsW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ps_d    = '0;
                rem_d   = '0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            ps_q         <= '0;
            rem_q        <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ps_q         <= ps_d;
            rem_q        <= rem_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign timer_done = done_q;
    assign timer_busy = busy_q;
    assign remaining  = rem_q;

endmodule

// File: tb/tb_timer_module.sv
// Bench for timer_module: two instances (PRESCALE 1 and 4) share stimulus; a time-based
// reference model pushes expected outputs into queues that a negedge monitor pops and checks.
module tb_timer_module;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_timer;
    logic [W-1:0] delay;
    logic         done1, busy1, done4, busy4;
    logic [W-1:0] rem1, rem4;

    always #5 clk = ~clk;

    timer_module #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start_timer(start_timer),
        .delay      (delay),
        .timer_done (done1),
        .timer_busy (busy1),
        .remaining  (rem1)
    );

    timer_module #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .start_timer(start_timer),
        .delay      (delay),
        .timer_done (done4),
        .timer_busy (busy4),
        .remaining  (rem4)
    );

    typedef struct packed {
        logic         done;
        logic         busy;
        logic [W-1:0] rem;
    } exp_t;

    exp_t sb1[$];
    exp_t sb4[$];

    int checks = 0;
    int errors = 0;

    // Reference model: a count started at cycle e0 with delay d finishes at e0 + d*P.
    int m_cyc = 0;
    bit m_prev = 1'b0;
    bit m_act[2];
    bit m_done[2];
    int m_e0[2];
    int m_dly[2];
    int pre[2] = '{1, 4};

    initial begin
        m_act  = '{1'b0, 1'b0};
        m_done = '{1'b0, 1'b0};
        m_e0   = '{0, 0};
        m_dly  = '{0, 0};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model update on the clock edge, expectation pushed once async reset has settled.
    always @(posedge clk) begin
        bit ev;
        bit was;
        exp_t e;
        if (reset) begin
            m_cyc++;
            ev     = start_timer && !m_prev;
            m_prev = start_timer;
            for (int i = 0; i < 2; i++) begin
                was = m_act[i];
                if (m_act[i] && (m_cyc - m_e0[i]) >= m_dly[i] * pre[i]) begin
                    m_act[i]  = 1'b0;
                    m_done[i] = 1'b1;
                end
                if (!was && ev) begin
                    m_e0[i]   = m_cyc;
                    m_dly[i]  = int'(delay);
                    m_act[i]  = (delay != 0);
                    m_done[i] = (delay == 0);
                end
            end
        end
        #2;
        if (!reset) begin
            m_prev = 1'b0;
            m_act  = '{1'b0, 1'b0};
            m_done = '{1'b0, 1'b0};
        end
        for (int i = 0; i < 2; i++) begin
            e.done = m_done[i];
            e.busy = m_act[i];
            e.rem  = m_act[i] ? W'(m_dly[i] - (m_cyc - m_e0[i]) / pre[i]) : '0;
            if (i == 0) sb1.push_back(e);
            else sb4.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("done_p1", 32'(done1), 32'(e.done));
            chk("busy_p1", 32'(busy1), 32'(e.busy));
            chk("rem_p1", 32'(rem1), 32'(e.rem));
        end
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            chk("done_p4", 32'(done4), 32'(e.done));
            chk("busy_p4", 32'(busy4), 32'(e.busy));
            chk("rem_p4", 32'(rem4), 32'(e.rem));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        start_timer = 1'b0;
        delay       = '0;

        // Start held high through reset release is accepted on the first edge.
        cycles(10);
        delay       = 16'd100;
        reset       = 1'b1;
        start_timer = 1'b1;
        cycles(160);

        // One-cycle reset pulse with start still high re-triggers with the new delay.
        reset = 1'b0;
        delay = 16'd50;
        cycles(1);
        reset = 1'b1;
        cycles(60);

        // Reset mid-count aborts; no done afterwards.
        start_timer = 1'b0;
        cycles(1);
        delay       = 16'd20;
        start_timer = 1'b1;
        cycles(10);
        reset       = 1'b0;
        start_timer = 1'b0;
        cycles(1);
        reset = 1'b1;
        cycles(30);

        // Restart attempt during RUN is ignored.
        delay       = 16'd30;
        start_timer = 1'b1;
        cycles(10);
        start_timer = 1'b0;
        cycles(1);
        start_timer = 1'b1;
        delay       = 16'd5;
        cycles(25);

        // Zero delay, then delay of one.
        start_timer = 1'b0;
        delay       = 16'd0;
        cycles(1);
        start_timer = 1'b1;
        cycles(3);
        start_timer = 1'b0;
        delay       = 16'd1;
        cycles(1);
        start_timer = 1'b1;
        cycles(5);

        // Let the prescaled instance finish, then a short prescaled count.
        start_timer = 1'b0;
        cycles(200);
        delay       = 16'd3;
        start_timer = 1'b1;
        cycles(20);

        // Maximum delay loads and counts down without wrapping; aborted by reset.
        start_timer = 1'b0;
        cycles(1);
        delay       = 16'hFFFF;
        start_timer = 1'b1;
        cycles(20);
        reset       = 1'b0;
        start_timer = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(2);

        // Randomized phase.
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) < 3) start_timer = ~start_timer;
            delay = W'($urandom_range(0, 20));
            cycles(1);
        end

        reset       = 1'b1;
        start_timer = 1'b0;
        cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
